// File: rtl/unary_dac_pkg.sv
// unary_dac_pkg: shared mode/direction types and code-width helper for the unary DAC controller
package unary_dac_pkg;
   typedef enum logic [1:0] {MODE_RAW, MODE_THERM, MODE_SAW, MODE_TRI} mode_e;
   typedef enum logic {UP, DOWN} tri_e;
   function automatic int code_width(input int n_cells);
      return $clog2(n_cells + 1);
   endfunction
endpackage

// File: rtl/therm_decoder.sv
// therm_decoder: binary code to thermometer cell vector plus per-group OR enables
module therm_decoder
   import unary_dac_pkg::*;
#(
   parameter int N_CELLS  = 128,
   parameter int N_GROUPS = 4,
   parameter int CODE_W   = code_width(N_CELLS)
) (
   input  logic [CODE_W-1:0]   code,
   output logic [N_CELLS-1:0]  on,
   output logic [N_GROUPS-1:0] en
);
   localparam int GS = N_CELLS / N_GROUPS;
   for (genvar i = 0; i < N_CELLS; i++) begin : g_cell
      assign on[i] = CODE_W'(i) < code;
   end
   for (genvar g = 0; g < N_GROUPS; g++) begin : g_grp
      assign en[g] = |on[g*GS +: GS];
   end
endmodule

// File: rtl/unary_dac_ctrl.sv
// unary_dac_ctrl: serial chain, thermometer load and sawtooth/triangle ramp control for a unary DAC array
module unary_dac_ctrl
   import unary_dac_pkg::*;
#(
   parameter int N_CELLS  = 128,
   parameter int N_GROUPS = 4,
   parameter int CODE_W   = code_width(N_CELLS),
   parameter int DIV_W    = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                datum_i,
   input  logic                shift_i,
   input  logic                transfer_i,
   input  logic                dir_i,
   input  logic [1:0]          mode_i,
   input  logic [CODE_W-1:0]   code_i,
   input  logic                code_load_i,
   input  logic [DIV_W-1:0]    ramp_div_i,
   output logic [N_CELLS-1:0]  on_o,
   output logic [N_GROUPS-1:0] en_o,
   output logic [CODE_W-1:0]   code_o,
   output logic                serial_o,
   output logic                wrap_o
);
   localparam int L = N_CELLS + N_GROUPS;
   localparam logic [CODE_W-1:0] FULL = CODE_W'(N_CELLS);
   localparam logic [CODE_W-1:0] ONE  = CODE_W'(1);
   logic [L-1:0]        chain;
   logic [DIV_W-1:0]    pre, pre_nxt;
   logic [CODE_W-1:0]   code_nxt;
   logic [1:0]          mode_q;
   tri_e                dir_q, dir_nxt;
   logic                wrap_nxt, ramp, mode_chg, tick;
   logic [N_CELLS-1:0]  dec_on;
   logic [N_GROUPS-1:0] dec_en;
   therm_decoder #(.N_CELLS(N_CELLS), .N_GROUPS(N_GROUPS), .CODE_W(CODE_W)) u_dec (
      .code(code_o),
      .on(dec_on),
      .en(dec_en)
   );
   assign ramp     = mode_i == MODE_SAW || mode_i == MODE_TRI;
   assign mode_chg = mode_i != mode_q;
   assign tick     = ramp && !mode_chg && !code_load_i && pre >= ramp_div_i;
   assign serial_o = chain[L-1];
   // a code load or mode change suppresses the ramp step in that cycle
   always_comb begin
      code_nxt = code_load_i ? (code_i > FULL ? FULL : code_i) : code_o;
      pre_nxt  = (mode_chg || code_load_i || tick || !ramp) ? '0 : pre + 1'b1;
      dir_nxt  = mode_chg ? UP : dir_q;
      wrap_nxt = 1'b0;
      if (tick && mode_i == MODE_SAW) begin
         code_nxt = code_o == FULL ? '0 : code_o + 1'b1;
         wrap_nxt = code_o == FULL;
      end else if (tick && dir_q == UP) begin
         code_nxt = code_o == FULL ? FULL - 1'b1 : code_o + 1'b1;
         dir_nxt  = code_o >= FULL - 1'b1 ? DOWN : UP;
         wrap_nxt = code_o == FULL - 1'b1;
      end else if (tick) begin
         code_nxt = code_o == '0 ? ONE : code_o - 1'b1;
         dir_nxt  = code_o <= ONE ? UP : DOWN;
         wrap_nxt = code_o == ONE;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chain  <= '0;
         on_o   <= '0;
         en_o   <= '0;
         code_o <= '0;
         pre    <= '0;
         wrap_o <= 1'b0;
         dir_q  <= UP;
         mode_q <= MODE_RAW;
      end else begin
         code_o <= code_nxt;
         pre    <= pre_nxt;
         dir_q  <= dir_nxt;
         wrap_o <= wrap_nxt;
         mode_q <= mode_i;
         if (transfer_i) begin
            if (!dir_i) chain <= {en_o, on_o};
         end else if (shift_i) chain <= {chain[L-2:0], datum_i};
         if (mode_i != MODE_RAW) {en_o, on_o} <= {dec_en, dec_on};
         else if (transfer_i && dir_i) {en_o, on_o} <= chain;
      end
   end
endmodule

// File: doc/unary_dac_ctrl.md
Name: unary_dac_ctrl

Overview:
- Parametrised controller driving one unary current-steering DAC array: N_CELLS cell-on bits plus N_GROUPS group-enable bits.
- Next generation of the serial daisychain/state-transfer front end.
- Adds binary-code thermometer loading, a self-running sawtooth/triangle ramp and serial readback.
- Sits between the pad-level control inputs and the inverterpair driver rows that feed the DAC macro.

Parameters:
- N_CELLS, 128, number of unary cells; must be a multiple of N_GROUPS.
- N_GROUPS, 4, number of enable groups; group g covers cells [g*N_CELLS/N_GROUPS +: N_CELLS/N_GROUPS].
- CODE_W, $clog2(N_CELLS+1), code width.
- DIV_W, 8, ramp prescaler width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- datum_i  in  1  serial data into chain bit 0
- shift_i  in  1  shift chain one position per cycle
- transfer_i  in  1  move data between chain and active register
- dir_i  in  1  1: chain->active, 0: active->chain (capture)
- mode_i  in  2  0 RAW, 1 THERM, 2 SAW, 3 TRI
- code_i  in  CODE_W  binary code
- code_load_i  in  1  load code_i into code register
- ramp_div_i  in  DIV_W  ramp step every ramp_div_i+1 cycles
- on_o  out  N_CELLS  active cell-on vector (registered)
- en_o  out  N_GROUPS  active group enables (registered)
- code_o  out  CODE_W  current code register
- serial_o  out  1  chain MSB (bit N_CELLS+N_GROUPS-1)
- wrap_o  out  1  one-cycle pulse at ramp wrap/turn

Behaviour:
- Reset: chain, on_o, en_o, code_o, prescaler, wrap_o all 0; triangle direction UP. Async assert, sync release.
- Chain is N_CELLS+N_GROUPS bits, layout {en, on}.
- Chain priority per cycle: transfer_i > shift_i.
- Shift: chain <= {chain[L-2:0], datum_i}.
- Transfer dir_i=0: chain <= {en_o, on_o} in every mode.
- Transfer dir_i=1 in RAW: {en_o, on_o} <= chain, one-cycle latency. Ignored in other modes; chain unchanged.
- RAW: on_o/en_o change only via transfer; code register holds.
- THERM/SAW/TRI: on_o[i] = (i < code), with code saturating at N_CELLS. en_o[g] = OR of group g cells. Registered one cycle after code_o changes.
- code_load_i: code_o <= min(code_i, N_CELLS) in any mode; prescaler cleared. Takes priority over a ramp step in the same cycle.
- Prescaler: runs only in SAW/TRI. Counts 0..ramp_div_i; at terminal count it steps the code and clears. ramp_div_i=0 steps every cycle.
- SAW: code +1; at N_CELLS next step gives 0 with wrap_o=1 in that step cycle.
- TRI, state UP: code +1. On reaching N_CELLS, state -> DOWN and wrap_o=1.
- TRI, state DOWN: code -1. On reaching 0, state -> UP and wrap_o=1.
- Any change of mode_i clears the prescaler and sets TRI state to UP; code is retained.
- Entering RAW freezes on_o/en_o at their last values.
- Reset mid-ramp returns everything to reset values immediately.

Decomposition:
- Package unary_dac_pkg: mode enum (MODE_RAW, MODE_THERM, MODE_SAW, MODE_TRI), tri-state enum (UP, DOWN), code-width helper function.
- Sub-module therm_decoder: combinational code -> on vector and group-OR enables, parametrised N_CELLS/N_GROUPS.
- Registering stays in the top block.

Test Plan:
- RAW shift 132 bits (pattern 0xF followed by 128'h1) then transfer dir=1 -> en_o=4'hF, on_o=128'h1 the next cycle. serial_o follows chain MSB throughout shifting.
- THERM code_load 37 -> one cycle later on_o has bits 0..36 set, en_o=4'b0011. code_load 200 -> code_o=128, on_o all ones, en_o=4'hF.
- SAW ramp_div=2, code 126 -> steps every 3 cycles: 127, 128, 0. wrap_o high only in the cycle code 128->0.
- TRI ramp_div=0, code 127 -> 128 (wrap_o), 127, 126, ...; after reaching 0, wrap_o pulses and the next value is 1.
- Simultaneous transfer_i=1 and shift_i=1 with dir=0 -> chain = {en_o, on_o}, no shift. code_load in the same cycle as a ramp step -> loaded value wins.
- Assert rst during TRI DOWN at code 50 -> all outputs 0 asynchronously. After release, mode TRI counts upward from 0.
